// File: rtl/jt12_div_pkg.sv
// jt12_div_pkg: prescaler divider codes and code/N conversion helpers
package jt12_div_pkg;
  localparam logic [1:0] DIV_NOP = 2'b00;
  localparam logic [1:0] DIV6    = 2'b01;
  localparam logic [1:0] DIV3    = 2'b10;
  localparam logic [1:0] DIV2    = 2'b11;
  function automatic logic [2:0] code2n(input logic [1:0] c);
    return c == DIV3 ? 3'd3 : c == DIV2 ? 3'd2 : 3'd6;
  endfunction
  function automatic logic [1:0] n2code(input logic [2:0] n);
    return n == 3'd3 ? DIV3 : n == 3'd2 ? DIV2 : DIV6;
  endfunction
endpackage

// File: rtl/jt12_cen_cnt.sv
// jt12_cen_cnt: modulo-N counter (clk, rst_n, n_nxt in; cen, wrap, n out) that loads a new N only at wrap
module jt12_cen_cnt #(
  parameter logic [2:0] N_RST = 3'd6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] n_nxt,
  output logic       cen,
  output logic       wrap,
  output logic [2:0] n
);
  logic [2:0] cnt;
  assign wrap = cnt == n - 3'd1;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 3'd0;
      cen <= 1'b0;
      n   <= N_RST;
    end else begin
      cen <= wrap;
      cnt <= wrap ? 3'd0 : cnt + 3'd1;
      if (wrap) n <= n_nxt;
    end
  end
endmodule

// File: rtl/jt12_div_ctl.sv
// jt12_div_ctl: prescaler controller (clk, rst_n, cmd_we, cmd in; cen, cen_ph, div_cur, busy, rst_int out)
module jt12_div_ctl
  import jt12_div_pkg::*;
#(
  parameter int DIV_RST  = 6,
  parameter int RST_CENS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_we,
  input  logic [1:0] cmd,
  output logic       cen,
  output logic       cen_ph,
  output logic [1:0] div_cur,
  output logic       busy,
  output logic       rst_int
);
  logic       valid, wrap;
  logic [1:0] pend;
  logic [2:0] n, n_nxt, rcnt;
  assign valid   = cmd_we && cmd != DIV_NOP;
  // a command on the wrap edge itself bypasses the pending register
  assign n_nxt   = valid ? code2n(cmd) : busy ? code2n(pend) : n;
  assign div_cur = n2code(n);
  jt12_cen_cnt #(.N_RST(3'(DIV_RST))) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .n_nxt(n_nxt),
    .cen  (cen),
    .wrap (wrap),
    .n    (n)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      pend    <= DIV_NOP;
      cen_ph  <= 1'b0;
      rcnt    <= 3'd0;
      rst_int <= 1'b1;
    end else begin
      if (wrap) busy <= 1'b0;
      else if (valid) begin
        busy <= 1'b1;
        pend <= cmd;
      end
      if (cen) cen_ph <= ~cen_ph;
      if (cen && rst_int) begin
        rcnt <= rcnt + 3'd1;
        if (rcnt + 3'd1 == 3'(RST_CENS)) rst_int <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_jt12_div_ctl.sv
// tb_jt12_div_ctl: randomized and directed check of jt12_div_ctl against an edge-count model
module tb_jt12_div_ctl;
  logic clk = 1'b0, rst_n = 1'b0, cmd_we = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic cen, cen_ph, busy, rst_int;
  logic [1:0] div_cur;
  int total = 0, bad = 0;
  int k = 0, ps = 0, mn = 6, mp = 0, mpc = 0, ncen = 0;
  bit mcen = 0;
  bit hcen[0:63], hbusy[0:63], hrst[0:63];
  int hdiv[0:63];

  jt12_div_ctl dut (
    .clk(clk), .rst_n(rst_n), .cmd_we(cmd_we), .cmd(cmd),
    .cen(cen), .cen_ph(cen_ph), .div_cur(div_cur), .busy(busy), .rst_int(rst_int)
  );

  always #5 clk = ~clk;

  function automatic int n_of(input int c);
    return c == 2 ? 3 : c == 3 ? 2 : 6;
  endfunction
  function automatic int code_of(input int n);
    return n == 3 ? 2 : n == 2 ? 3 : 1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0d want=%0d", nm, k, act, exp);
    end
  endtask

  // model: a period starts at edge ps and the next cen lands at edge ps+mn
  task automatic step(input bit rn, input bit we, input logic [1:0] c);
    @(negedge clk);
    rst_n = rn; cmd_we = we; cmd = c;
    @(posedge clk);
    if (!rn) begin
      k = 0; ps = 0; mn = 6; mp = 0; mpc = 0; ncen = 0; mcen = 0;
    end else begin
      k++;
      if (mcen) ncen++;
      if (k == ps + mn) begin
        mcen = 1; ps = k;
        mn = (we && c != 0) ? n_of(int'(c)) : mp != 0 ? n_of(mpc) : mn;
        mp = 0;
      end else begin
        mcen = 0;
        if (we && c != 0) begin mp = 1; mpc = int'(c); end
      end
    end
    #1;
    chk("cen", int'(cen), int'(mcen));
    chk("cen_ph", int'(cen_ph), ncen % 2);
    chk("rst_int", int'(rst_int), ncen < 2 ? 1 : 0);
    chk("busy", int'(busy), mp);
    chk("div_cur", int'(div_cur), code_of(mn));
    if (k < 64) begin
      hcen[k] = cen; hbusy[k] = busy; hrst[k] = rst_int; hdiv[k] = int'(div_cur);
    end
  endtask

  initial begin
    step(0, 0, 0); step(0, 0, 0);
    chk("reset_rst_int", int'(rst_int), 1);
    chk("reset_div", int'(div_cur), 1);
    for (int i = 1; i <= 20; i++) step(1, 0, 0);
    chk("lit_cen6", int'(hcen[6]), 1);
    chk("lit_cen12", int'(hcen[12]), 1);
    chk("lit_cen18", int'(hcen[18]), 1);
    chk("lit_cen5", int'(hcen[5]), 0);
    chk("lit_cen7", int'(hcen[7]), 0);
    chk("lit_rst12", int'(hrst[12]), 1);
    chk("lit_rst13", int'(hrst[13]), 0);
    chk("lit_div18", hdiv[18], 1);
    step(0, 0, 0);
    for (int i = 1; i <= 20; i++) step(1, i == 8, i == 8 ? 2'b11 : 2'b00);
    for (int i = 9; i <= 11; i++) chk("lit_busy_pend", int'(hbusy[i]), 1);
    chk("lit_busy12", int'(hbusy[12]), 0);
    chk("lit_div2_cen14", int'(hcen[14]), 1);
    chk("lit_div2_cen16", int'(hcen[16]), 1);
    chk("lit_div2_cen13", int'(hcen[13]), 0);
    chk("lit_div2_code", hdiv[13], 3);
    for (int i = 21; i <= 32; i++) step(1, i == 22, i == 22 ? 2'b01 : 2'b00);
    chk("lit_wrapcmd_busy", int'(hbusy[22]), 0);
    chk("lit_wrapcmd_cen22", int'(hcen[22]), 1);
    chk("lit_wrapcmd_cen24", int'(hcen[24]), 0);
    chk("lit_wrapcmd_cen28", int'(hcen[28]), 1);
    step(0, 0, 0);
    for (int i = 1; i <= 14; i++) step(1, i == 3 || i == 4, 2'b00);
    chk("lit_nop_busy3", int'(hbusy[3]), 0);
    chk("lit_nop_busy4", int'(hbusy[4]), 0);
    chk("lit_nop_cen12", int'(hcen[12]), 1);
    step(0, 0, 0);
    for (int i = 1; i <= 14; i++) step(1, i == 2 || i == 4, i == 2 ? 2'b10 : i == 4 ? 2'b11 : 2'b00);
    chk("lit_ovr_cen8", int'(hcen[8]), 1);
    chk("lit_ovr_div", hdiv[7], 3);
    step(0, 0, 0);
    for (int i = 1; i <= 10; i++) step(1, i == 2 || i == 10, i == 2 ? 2'b10 : i == 10 ? 2'b11 : 2'b00);
    chk("lit_mid_busy", int'(busy), 1);
    step(0, 0, 0);
    chk("lit_mid_rst_busy", int'(busy), 0);
    chk("lit_mid_rst_int", int'(rst_int), 1);
    chk("lit_mid_rst_div", int'(div_cur), 1);
    for (int i = 1; i <= 8; i++) step(1, 0, 0);
    chk("lit_mid_cen3", int'(hcen[3]), 0);
    chk("lit_mid_cen6", int'(hcen[6]), 1);
    repeat (3000) step($urandom_range(0, 99) != 0, $urandom_range(0, 3) == 0, 2'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
